// File: rtl/serial_full_subtractor_if.sv
// ---------------------------------------------------------------------------
// Module   : serial_full_subtractor_if
// Purpose  : Request/result bundle for the bit-serial subtractor.
// Revision : 1.0 - initial release
// Signals  :
//   start     master->slave  request, honoured only when the slave is idle
//   x, y      master->slave  minuend / subtrahend (WIDTH bits)
//   b0        master->slave  borrow-in
//   busy      slave->master  operation in progress
//   dbit      slave->master  serial difference bit of this cycle
//   dbit_vld  slave->master  dbit is valid
//   done      slave->master  one-cycle pulse, d/b_out final
//   d, b_out  slave->master  held difference and final borrow
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_full_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b0;
  logic             busy;
  logic             dbit;
  logic             dbit_vld;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;

  modport master (
    output start, x, y, b0,
    input  busy, dbit, dbit_vld, done, d, b_out
  );

  modport slave (
    input  start, x, y, b0,
    output busy, dbit, dbit_vld, done, d, b_out
  );
endinterface

`default_nettype wire

// File: rtl/serial_full_subtractor.sv
// ---------------------------------------------------------------------------
// Module   : serial_full_subtractor
// Purpose  : Bit-serial subtractor, D = X - Y - B0 (mod 2^WIDTH), LSB first,
//            one full-subtractor step per clock with a registered borrow.
// Revision : 1.0 - initial release
// Ports    :
//   clk_i   in   rising-edge clock
//   rst_ni  in   synchronous active-low reset
//   bus_if  slave modport of serial_full_subtractor_if (request + results)
// ---------------------------------------------------------------------------
`default_nettype none

module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  serial_full_subtractor_if.slave   bus_if
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] xs_q;
  logic [WIDTH-1:0] ys_q;
  // Only WIDTH-1 partial bits are kept; the final bit joins them on the
  // last shift step, straight into the held result.
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             busy_q;
  logic             vld_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  logic             diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] res_d;

  // One full-subtractor step on the current LSBs.
  assign diff_d   = xs_q[0] ^ ys_q[0] ^ borrow_q;
  assign borrow_d = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & borrow_q);
  assign res_d    = {diff_d, res_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      case (state_q)
        // FIN accepts a new request exactly like IDLE for back-to-back use.
        IDLE, FIN: begin
          done_q <= 1'b0;
          if (bus_if.start) begin
            xs_q     <= bus_if.x;
            ys_q     <= bus_if.y;
            borrow_q <= bus_if.b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            vld_q    <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            state_q  <= IDLE;
          end
        end
        SHIFT: begin
          borrow_q <= borrow_d;
          xs_q     <= xs_q >> 1;
          ys_q     <= ys_q >> 1;
          res_q    <= res_d[WIDTH-1:1];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            d_q     <= res_d;
            bout_q  <= borrow_d;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          vld_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.busy     = busy_q;
  assign bus_if.dbit_vld = vld_q;
  // Gated so the tap reads 0 outside SHIFT rather than a stale borrow.
  assign bus_if.dbit     = vld_q & diff_d;
  assign bus_if.done     = done_q;
  assign bus_if.d        = d_q;
  assign bus_if.b_out    = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_full_subtractor.sv
// ---------------------------------------------------------------------------
// Module   : tb_serial_full_subtractor
// Purpose  : Self-checking bench for serial_full_subtractor (WIDTH=8 and 4).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_full_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n;
  logic rst4_n;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done4    = 0;

  always @(posedge clk) cyc++;

  serial_full_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_full_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk_i  (clk),
    .rst_ni (rst8_n),
    .bus_if (bus8)
  );

  serial_full_subtractor #(.WIDTH(4)) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst4_n),
    .bus_if (bus4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since the accepting edge
  // (0 = idle, 1..w = serial bits, w+1 = result cycle).
  typedef struct {
    int         age;
    int         ops;
    logic [7:0] pend_d;
    logic       pend_b;
    logic [7:0] held_d;
    logic       held_b;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, int w, logic rn, logic st,
                                    logic [7:0] x, logic [7:0] y, logic b0);
    mdl_t r = m;
    int   xi = int'(x);
    int   yi = int'(y);
    int   bi = int'(b0);
    if (!rn) begin
      r.age    = 0;
      r.held_d = 8'h00;
      r.held_b = 1'b0;
    end else if ((m.age == 0 || m.age == w + 1) && st) begin
      r.age    = 1;
      r.ops    = m.ops + 1;
      r.pend_d = 8'((xi - yi - bi) & ((1 << w) - 1));
      r.pend_b = (xi < yi + bi);
    end else if (m.age >= 1 && m.age <= w) begin
      r.age = m.age + 1;
      if (r.age == w + 1) begin
        r.held_d = m.pend_d;
        r.held_b = m.pend_b;
      end
    end else begin
      r.age = 0;
    end
    return r;
  endfunction

  mdl_t m8 = '{0, 0, 8'h00, 1'b0, 8'h00, 1'b0};
  mdl_t m4 = '{0, 0, 8'h00, 1'b0, 8'h00, 1'b0};
  bit   en8 = 1'b0;
  bit   en4 = 1'b0;

  always @(posedge clk) begin
    m8 = mdl_step(m8, 8, rst8_n, bus8.start, bus8.x, bus8.y, bus8.b0);
    m4 = mdl_step(m4, 4, rst4_n, bus4.start, {4'h0, bus4.x}, {4'h0, bus4.y}, bus4.b0);
    if (!rst8_n) en8 = 1'b1;
    if (!rst4_n) en4 = 1'b1;
  end

  logic        e8_busy, e4_busy;
  logic [12:0] act8, exp8, act4, exp4;

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (bus4.done === 1'b1) done4++;
    if (en8) begin
      e8_busy = (m8.age >= 1 && m8.age <= 8);
      act8 = {bus8.busy, bus8.dbit_vld, (m8.age == 9) ? 1'b1 : 1'b0, bus8.b_out, bus8.d,
              e8_busy ? bus8.dbit : 1'b0};
      act8[10] = bus8.done;
      exp8 = {e8_busy, e8_busy, (m8.age == 9) ? 1'b1 : 1'b0, m8.held_b, m8.held_d,
              e8_busy ? m8.pend_d[m8.age - 1] : 1'b0};
      check("model_w8", 32'(act8), 32'(exp8));
    end
    if (en4) begin
      e4_busy = (m4.age >= 1 && m4.age <= 4);
      act4 = {bus4.busy, bus4.dbit_vld, bus4.done, bus4.b_out, 4'h0, bus4.d,
              e4_busy ? bus4.dbit : 1'b0};
      exp4 = {e4_busy, e4_busy, (m4.age == 5) ? 1'b1 : 1'b0, m4.held_b, m4.held_d,
              e4_busy ? m4.pend_d[m4.age - 1] : 1'b0};
      check("model_w4", 32'(act4), 32'(exp4));
    end
  end

  // Waits for DONE on the 8-bit DUT, collecting serial bits on the way.
  task automatic wait_done(input int t0, output int lat, output logic [7:0] bits);
    int k = 0;
    bits = 8'h00;
    lat  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus8.dbit_vld === 1'b1 && k < 8) begin
        bits[k] = bus8.dbit;
        k++;
      end
      if (bus8.done === 1'b1) begin
        lat = cyc - t0 + 1;
        return;
      end
    end
  endtask

  task automatic op8(input string name, input logic [7:0] x, input logic [7:0] y,
                     input logic b0, input logic [7:0] ed, input logic eb,
                     input bit chk_bits, input logic [7:0] ebits);
    int         t0;
    int         lat;
    logic [7:0] bits;
    bus8.x     = x;
    bus8.y     = y;
    bus8.b0    = b0;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus8.start = 1'b0;
    wait_done(t0, lat, bits);
    check({name, "_latency"}, 32'(lat), 32'd9);
    check({name, "_d"}, 32'(bus8.d), 32'(ed));
    check({name, "_bout"}, 32'(bus8.b_out), 32'(eb));
    if (chk_bits) check({name, "_dbits"}, 32'(bits), 32'(ebits));
    @(posedge clk); #1;
  endtask

  initial begin
    int         t0;
    int         lat;
    int         nd;
    logic [7:0] bits;

    rst8_n = 1'b0;
    rst4_n = 1'b0;
    bus8.start = 1'b0; bus8.x = 8'h00; bus8.y = 8'h00; bus8.b0 = 1'b0;
    bus4.start = 1'b0; bus4.x = 4'h0;  bus4.y = 4'h0;  bus4.b0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_w8", 32'({bus8.busy, bus8.dbit_vld, bus8.done, bus8.dbit, bus8.b_out, bus8.d}), 32'd0);
    check("reset_w4", 32'({bus4.busy, bus4.dbit_vld, bus4.done, bus4.dbit, bus4.b_out, bus4.d}), 32'd0);
    @(posedge clk); #1;
    rst8_n = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtraction with serial-bit sequence 0,1,0,0,0,0,0,0.
    op8("t1_05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1, 8'h02);
    // Underflow and borrow-in cases.
    op8("t2_03m05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b1, 8'hFE);
    op8("t2_00m00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);
    op8("t2_FFmFF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // START held high: back-to-back, mid-op operand changes ignored.
    bus8.x = 8'h80; bus8.y = 8'h01; bus8.b0 = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    bus8.x = 8'hAA; bus8.y = 8'h55; bus8.b0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus8.x = 8'h10; bus8.y = 8'h20; bus8.b0 = 1'b0;
    wait_done(t0, lat, bits);
    check("t3a_latency", 32'(lat), 32'd9);
    check("t3a_d", 32'(bus8.d), 32'h7F);
    check("t3a_bout", 32'(bus8.b_out), 32'd0);
    @(posedge clk); #1;
    t0 = cyc;
    bus8.start = 1'b0;
    wait_done(t0, lat, bits);
    check("t3b_latency", 32'(lat), 32'd9);
    check("t3b_d", 32'(bus8.d), 32'hF0);
    check("t3b_bout", 32'(bus8.b_out), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of an operation (cnt = 4).
    bus8.x = 8'h55; bus8.y = 8'h22; bus8.b0 = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    @(posedge clk); #1;
    rst8_n = 1'b1;
    @(negedge clk);
    check("t4_after_reset", 32'({bus8.busy, bus8.dbit_vld, bus8.done, bus8.dbit, bus8.b_out, bus8.d}), 32'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) nd++;
    end
    check("t4_no_done", 32'(nd), 32'd0);
    @(posedge clk); #1;
    op8("t4_55m22", 8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00);

    // WIDTH=4 exhaustive, back-to-back with START held high.
    for (int i = 0; i < 512; i++) begin
      bus4.x     = 4'(i >> 5);
      bus4.y     = 4'(i >> 1);
      bus4.b0    = 1'(i);
      bus4.start = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
    end
    bus4.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_done_count", 32'(done4), 32'd512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
